gpu_mem_arbiter: RTL and testbench
==================================

Name: gpu_mem_arbiter

Overview:
- Round-robin arbiter sharing the single GPU main external memory-mapped interface between NUM_REQ pipeline requesters.
- Requesters are the instruction fetch, vertex processing, primitive assembly and raster stages.
- Issues one transaction at a time, holds bus signals stable until acknowledge, and routes acknowledge and read data back to the winner.
- A per-transaction timeout guards against a missing acknowledge.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 30, word address width of the main interface.
- TIMEOUT_CYCLES, 1024, cycles in BUSY without acknowledge before abort (>=2).

Ports:
- clk_clk  in  1  system clock; all logic rising-edge.
- reset_reset_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request; held high until that requester's req_ack.
- req_write  in  NUM_REQ  1=write, 0=read.
- req_address  in  NUM_REQ*ADDR_W  flattened; slice i = requester i.
- req_byte_enable  in  NUM_REQ*4  flattened byte enables.
- req_write_data  in  NUM_REQ*32  flattened write data.
- req_ack  out  NUM_REQ  one-cycle completion pulse to the winner.
- req_err  out  NUM_REQ  one-cycle timeout pulse, coincident with req_ack.
- req_read_data  out  32  shared; valid only in the req_ack cycle.
- gpu_main_external_interface_address  out  ADDR_W  bus address.
- gpu_main_external_interface_byte_enable  out  4  bus byte enables.
- gpu_main_external_interface_read  out  1  read strobe.
- gpu_main_external_interface_write  out  1  write strobe.
- gpu_main_external_interface_write_data  out  32  bus write data.
- gpu_main_external_interface_acknowledge  in  1  transaction complete.
- gpu_main_external_interface_read_data  in  32  read data, valid with acknowledge.
- busy  out  1  high while in BUSY.
- grant_id  out  3  index of the current or last winner.

Behaviour:
- Reset (reset_reset_n low at a clock edge, including mid-transaction):
  - All outputs go to 0: strobes, address, byte_enable, write_data, req_ack, req_err, req_read_data, busy, grant_id.
  - State goes to IDLE, the timeout counter clears, and the round-robin pointer is set so requester 0 has top priority.
  - An in-flight bus transaction is abandoned; a late acknowledge is ignored.
- All outputs are registered.
- State IDLE:
  - If any req_valid is high, the winner is the first set bit searching from (last_grant+1) mod NUM_REQ upward, with wrap-around.
  - On the next edge: the winner's address, byte_enable and write_data are latched onto the bus outputs.
  - Write is asserted if req_write[i]=1, otherwise read.
  - grant_id <= i, last_grant <= i, busy <= 1, timeout counter <= 0, state -> BUSY.
  - Latency: req_valid sampled high in cycle t gives a strobe high in cycle t+1.
- State BUSY:
  - All bus outputs are held constant.
  - req_valid and payload changes from any requester are ignored.
  - The counter increments each cycle.
- Acknowledge in BUSY, sampled in cycle k:
  - Cycle k+1: strobes low, req_ack[i]=1, req_read_data = sampled read_data (writes return the sampled value, don't-care).
  - busy=0 and state -> IDLE.
  - The earliest next strobe is cycle k+2, so there is a guaranteed idle bus cycle between transactions.
- Timeout: if the counter reaches TIMEOUT_CYCLES-1 without acknowledge:
  - Next cycle: strobes low, req_ack[i]=1, req_err[i]=1, req_read_data=0, state -> IDLE.
  - If acknowledge and timeout occur in the same cycle, acknowledge wins: normal completion, no err.
- Acknowledge in IDLE is ignored.
- req_ack and req_err are high for exactly one cycle and only for the granted index.
- A requester must drop or change req_valid in the cycle after its req_ack. If it stays high, it is re-arbitrated as a new request at lowest priority, because the pointer has advanced.
- Fairness: with all requesters continuously requesting, grants cycle 0,1,..,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 transactions.
- A single requester may win back-to-back when no other is requesting.
- Out-of-range bits of grant_id (for NUM_REQ<8) are 0.

Test Plan:
1. Reset then single read from requester 2 at address 0x0000_1234 with byte_enable 0xF; memory model acknowledges 3 cycles after read rises with data 0xCAFEF00D → read high cycle t+1; req_ack[2] pulse one cycle after acknowledge with req_read_data=0xCAFEF00D; grant_id=2; other req_ack stay 0.
2. All 4 requesters assert writes simultaneously, 1-cycle acknowledge model → grant order 0,1,2,3, then 0 if still requesting; one idle bus cycle between each write; address and write_data match each slice.
3. Payload stability: requester 1 changes req_address during BUSY; requester 3 asserts mid-transaction → bus address unchanged until acknowledge; requester 3 served next.
4. Timeout: TIMEOUT_CYCLES=16, model never acknowledges a read from requester 0 → strobe drops after 16 cycles; req_ack[0] and req_err[0] pulse together; req_read_data=0; next request proceeds normally.
5. Acknowledge and timeout in the same cycle → normal completion with data, req_err=0. A spurious acknowledge while IDLE → no req_ack.
6. reset_reset_n driven low for 1 cycle while BUSY with read high → all outputs 0 next cycle; acknowledge arriving afterward is ignored; the first grant after reset goes to the lowest pending index.

Source files
------------

// File: rtl/gpu_mem_arbiter.sv
// Round-robin arbiter sharing the GPU main external memory interface among
// NUM_REQ pipeline requesters: one transaction in flight, guarded by an ack timeout.
module gpu_mem_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ADDR_W         = 30,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                      clk_clk,
   input  logic                      reset_reset_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_address,
   input  logic [NUM_REQ*4-1:0]      req_byte_enable,
   input  logic [NUM_REQ*32-1:0]     req_write_data,
   output logic [NUM_REQ-1:0]        req_ack,
   output logic [NUM_REQ-1:0]        req_err,
   output logic [31:0]               req_read_data,
   output logic [ADDR_W-1:0]         gpu_main_external_interface_address,
   output logic [3:0]                gpu_main_external_interface_byte_enable,
   output logic                      gpu_main_external_interface_read,
   output logic                      gpu_main_external_interface_write,
   output logic [31:0]               gpu_main_external_interface_write_data,
   input  logic                      gpu_main_external_interface_acknowledge,
   input  logic [31:0]               gpu_main_external_interface_read_data,
   output logic                      busy,
   output logic [2:0]                grant_id
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t             state;
   logic [IDX_W-1:0]   last_grant;
   logic [CNT_W-1:0]   cnt;
   logic               win_found;
   logic [IDX_W-1:0]   win_idx;
   logic [NUM_REQ-1:0] grant_mask;

   logic [ADDR_W-1:0]  addr_a [NUM_REQ];
   logic [3:0]         be_a   [NUM_REQ];
   logic [31:0]        wd_a   [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_a[g] = req_address[g*ADDR_W +: ADDR_W];
      assign be_a[g]   = req_byte_enable[g*4 +: 4];
      assign wd_a[g]   = req_write_data[g*32 +: 32];
   end

   // First requesting index after the previous winner, wrapping around.
   function automatic logic [IDX_W:0] pick_next(input logic [NUM_REQ-1:0] valid,
                                                input logic [IDX_W-1:0]   last);
      logic             found;
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] idx_c;
      int               cand;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand  = (int'(last) + k) % NUM_REQ;
         idx_c = IDX_W'(cand);
         if (!found && valid[idx_c]) begin
            found = 1'b1;
            idx   = idx_c;
         end
      end
      return {found, idx};
   endfunction

   assign {win_found, win_idx} = pick_next(req_valid, last_grant);
   assign grant_mask = NUM_REQ'(1) << last_grant;

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state                                   <= ST_IDLE;
         last_grant                              <= IDX_W'(NUM_REQ - 1);
         cnt                                     <= '0;
         req_ack                                 <= '0;
         req_err                                 <= '0;
         req_read_data                           <= '0;
         gpu_main_external_interface_address     <= '0;
         gpu_main_external_interface_byte_enable <= '0;
         gpu_main_external_interface_read        <= 1'b0;
         gpu_main_external_interface_write       <= 1'b0;
         gpu_main_external_interface_write_data  <= '0;
         busy                                    <= 1'b0;
         grant_id                                <= '0;
      end else begin
         req_ack <= '0;
         req_err <= '0;
         case (state)
            ST_IDLE: begin
               if (win_found) begin
                  gpu_main_external_interface_address     <= addr_a[win_idx];
                  gpu_main_external_interface_byte_enable <= be_a[win_idx];
                  gpu_main_external_interface_write_data  <= wd_a[win_idx];
                  gpu_main_external_interface_write       <= req_write[win_idx];
                  gpu_main_external_interface_read        <= ~req_write[win_idx];
                  grant_id                                <= 3'(win_idx);
                  last_grant                              <= win_idx;
                  busy                                    <= 1'b1;
                  cnt                                     <= '0;
                  state                                   <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               // Acknowledge takes precedence over a timeout landing on the same edge.
               if (gpu_main_external_interface_acknowledge) begin
                  gpu_main_external_interface_read  <= 1'b0;
                  gpu_main_external_interface_write <= 1'b0;
                  req_ack                           <= grant_mask;
                  req_read_data                     <= gpu_main_external_interface_read_data;
                  busy                              <= 1'b0;
                  state                             <= ST_IDLE;
               end else if (cnt == CNT_LAST) begin
                  gpu_main_external_interface_read  <= 1'b0;
                  gpu_main_external_interface_write <= 1'b0;
                  req_ack                           <= grant_mask;
                  req_err                           <= grant_mask;
                  req_read_data                     <= '0;
                  busy                              <= 1'b0;
                  state                             <= ST_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// Bench for gpu_mem_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a transaction-level round-robin model.
module tb_gpu_mem_arbiter;

   localparam int N  = 4;
   localparam int AW = 30;
   localparam int TO = 16;
   localparam int IW = 2;

   logic            clk_clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_write;
   logic [AW-1:0]   addr_a [N];
   logic [3:0]      be_a   [N];
   logic [31:0]     wd_a   [N];
   logic [N*AW-1:0] req_address;
   logic [N*4-1:0]  req_be;
   logic [N*32-1:0] req_wd;
   logic [N-1:0]    req_ack;
   logic [N-1:0]    req_err;
   logic [31:0]     req_rdata;
   logic [AW-1:0]   bus_addr;
   logic [3:0]      bus_be;
   logic            bus_rd;
   logic            bus_wr;
   logic [31:0]     bus_wd;
   logic            mem_ack;
   logic [31:0]     mem_rdata;
   logic            busy;
   logic [2:0]      grant_id;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_clk = ~clk_clk;

   always_comb begin
      req_address = '0;
      req_be      = '0;
      req_wd      = '0;
      for (int i = 0; i < N; i++) begin
         req_address[i*AW +: AW] = addr_a[i];
         req_be[i*4 +: 4]        = be_a[i];
         req_wd[i*32 +: 32]      = wd_a[i];
      end
   end

   gpu_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
      .clk_clk                                 (clk_clk),
      .reset_reset_n                           (rst_n),
      .req_valid                               (req_valid),
      .req_write                               (req_write),
      .req_address                             (req_address),
      .req_byte_enable                         (req_be),
      .req_write_data                          (req_wd),
      .req_ack                                 (req_ack),
      .req_err                                 (req_err),
      .req_read_data                           (req_rdata),
      .gpu_main_external_interface_address     (bus_addr),
      .gpu_main_external_interface_byte_enable (bus_be),
      .gpu_main_external_interface_read        (bus_rd),
      .gpu_main_external_interface_write       (bus_wr),
      .gpu_main_external_interface_write_data  (bus_wd),
      .gpu_main_external_interface_acknowledge (mem_ack),
      .gpu_main_external_interface_read_data   (mem_rdata),
      .busy                                    (busy),
      .grant_id                                (grant_id)
   );

   typedef struct {
      logic [1:0]  id;
      logic        wr;
      logic [29:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
      int          dly;     // cycles after strobe rise before ack; -1 = never
      logic [31:0] rd;
      int          lat;     // expected cycles from strobe rise to req_ack
      logic        err;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [6];

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic tick();
      @(posedge clk_clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_addr"},  64'(bus_addr),  64'(0));
      chk({tag, "_be"},    64'(bus_be),    64'(0));
      chk({tag, "_rd"},    64'(bus_rd),    64'(0));
      chk({tag, "_wr"},    64'(bus_wr),    64'(0));
      chk({tag, "_wd"},    64'(bus_wd),    64'(0));
      chk({tag, "_ack"},   64'(req_ack),   64'(0));
      chk({tag, "_err"},   64'(req_err),   64'(0));
      chk({tag, "_rdata"}, 64'(req_rdata), 64'(0));
      chk({tag, "_busy"},  64'(busy),      64'(0));
      chk({tag, "_gid"},   64'(grant_id),  64'(0));
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      mem_ack   = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic run_single(input vec_t v);
      int   lat;
      logic done;
      req_valid       = '0;
      req_valid[v.id] = 1'b1;
      req_write[v.id] = v.wr;
      addr_a[v.id]    = v.addr;
      be_a[v.id]      = v.be;
      wd_a[v.id]      = v.wd;
      tick();
      chk("vec_strobe", 64'({bus_rd, bus_wr}), 64'({~v.wr, v.wr}));
      chk("vec_addr",   64'(bus_addr), 64'(v.addr));
      chk("vec_be",     64'(bus_be),   64'(v.be));
      chk("vec_wd",     64'(bus_wd),   64'(v.wd));
      chk("vec_gid",    64'(grant_id), 64'(v.id));
      chk("vec_busy",   64'(busy),     64'(1));
      addr_a[v.id] = ~v.addr;
      done = 1'b0;
      lat  = 0;
      while (!done && lat < 40) begin
         mem_ack   = (lat == v.dly);
         mem_rdata = mem_ack ? v.rd : (32'hDEAD_0000 | 32'(lat));
         tick();
         lat++;
         mem_ack = 1'b0;
         if (req_ack != '0) done = 1'b1;
         else begin
            chk("vec_hold_addr",   64'(bus_addr), 64'(v.addr));
            chk("vec_hold_strobe", 64'({bus_rd, bus_wr}), 64'({~v.wr, v.wr}));
         end
      end
      chk("vec_ack_seen", 64'(done), 64'(1));
      chk("vec_latency",  64'(lat), 64'(v.lat));
      chk("vec_ack",      64'(req_ack), 64'(4'(1) << v.id));
      chk("vec_err",      64'(req_err), 64'(v.err ? (4'(1) << v.id) : 4'(0)));
      chk("vec_rdata",    64'(req_rdata), 64'(v.exp_rd));
      chk("vec_done_strobe", 64'({bus_rd, bus_wr, busy}), 64'(0));
      req_valid[v.id] = 1'b0;
      mem_ack   = (lat == v.dly);
      mem_rdata = 32'h0F0F_0F0F;
      tick();
      mem_ack = 1'b0;
      chk("vec_after_ack",  64'(req_ack), 64'(0));
      chk("vec_after_err",  64'(req_err), 64'(0));
      chk("vec_after_idle", 64'({bus_rd, bus_wr, busy}), 64'(0));
   endtask

   function automatic int rr_pick(input logic [N-1:0] v, input int last);
      int idx;
      for (int k = 1; k <= N; k++) begin
         idx = (last + k) % N;
         if (v[IW'(idx)]) return idx;
      end
      return -1;
   endfunction

   // Random-phase model state
   int            m_last, m_cur, m_start, m_gid, ack_at, d, r, e;
   logic          m_busy, m_wr, stopping, a_pre;
   logic [AW-1:0] m_addr;
   logic [3:0]    m_be;
   logic [31:0]   m_wd, rd_pre, e_rd;
   logic [N-1:0]  v_pre, e_ack, e_err;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{2'd2, 1'b0, 30'h0000_1234, 4'hF, 32'h0,         3,  32'hCAFE_F00D, 4,  1'b0, 32'hCAFE_F00D};
      vecs[1] = '{2'd0, 1'b0, 30'h3FFF_FFFF, 4'h1, 32'h0,         -1, 32'h1234_5678, 16, 1'b1, 32'h0};
      vecs[2] = '{2'd1, 1'b1, 30'h0000_0ABC, 4'h3, 32'h55AA_55AA, 0,  32'h1111_2222, 1,  1'b0, 32'h1111_2222};
      vecs[3] = '{2'd3, 1'b0, 30'h2000_0000, 4'hC, 32'h0,         15, 32'hA5A5_5A5A, 16, 1'b0, 32'hA5A5_5A5A};
      vecs[4] = '{2'd0, 1'b0, 30'h0000_0010, 4'h8, 32'h0,         14, 32'h0BAD_BEEF, 15, 1'b0, 32'h0BAD_BEEF};
      vecs[5] = '{2'd2, 1'b1, 30'h1555_5555, 4'h6, 32'hFEED_FACE, 16, 32'h7777_7777, 16, 1'b1, 32'h0};

      for (int i = 0; i < N; i++) begin
         addr_a[i] = '0;
         be_a[i]   = '0;
         wd_a[i]   = '0;
      end
      rst_n     = 1'b0;
      req_valid = '0;
      req_write = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      tick();
      tick();
      chk_zero("reset");
      rst_n = 1'b1;

      // Spurious acknowledge with nothing in flight
      mem_ack   = 1'b1;
      mem_rdata = 32'h5555_AAAA;
      tick();
      mem_ack = 1'b0;
      chk("idle_ack_ignored", 64'(req_ack), 64'(0));
      chk("idle_ack_busy",    64'({bus_rd, bus_wr, busy}), 64'(0));

      for (int i = 0; i < 6; i++) run_single(vecs[i]);

      // All four requesters write at once: rotation 0,1,2,3 then 0 again
      do_reset();
      for (int i = 0; i < N; i++) begin
         addr_a[i] = 30'h100 + 30'(i * 17);
         be_a[i]   = 4'hF;
         wd_a[i]   = 32'hA000_0000 + 32'(i);
      end
      req_write = '1;
      req_valid = '1;
      tick();
      for (int g = 0; g < 5; g++) begin
         e = g % N;
         chk("rr_grant",  64'(grant_id), 64'(e));
         chk("rr_strobe", 64'({bus_rd, bus_wr}), 64'(2'b01));
         chk("rr_addr",   64'(bus_addr), 64'(30'h100 + 30'(e * 17)));
         chk("rr_wdata",  64'(bus_wd),   64'(32'hA000_0000 + 32'(e)));
         mem_ack = 1'b1;
         tick();
         mem_ack = 1'b0;
         chk("rr_ack", 64'(req_ack), 64'(4'(1) << e));
         chk("rr_gap", 64'({bus_rd, bus_wr}), 64'(0));
         if (g == 3)      req_valid = '1;
         else if (g == 4) req_valid = '0;
         else             req_valid[IW'(e)] = 1'b0;
         tick();
      end
      chk("rr_idle", 64'({bus_rd, bus_wr, busy}), 64'(0));

      // Payload change during BUSY and late arrivals; pointer sits at 0
      req_write = '0;
      addr_a[1] = 30'h111;
      req_valid[1] = 1'b1;
      tick();
      chk("stab_grant", 64'(grant_id), 64'(1));
      chk("stab_read",  64'(bus_rd), 64'(1));
      addr_a[1] = 30'h999;
      addr_a[3] = 30'h333;
      addr_a[0] = 30'h444;
      req_valid[3] = 1'b1;
      req_valid[0] = 1'b1;
      tick();
      tick();
      chk("stab_addr_hold", 64'(bus_addr), 64'(30'h111));
      chk("stab_gid_hold",  64'(grant_id), 64'(1));
      mem_ack = 1'b1; mem_rdata = 32'h0000_0001;
      tick();
      mem_ack = 1'b0;
      chk("stab_ack1",  64'(req_ack), 64'(4'b0010));
      chk("stab_data1", 64'(req_rdata), 64'(32'h1));
      req_valid[1] = 1'b0;
      tick();
      chk("stab_next3", 64'(grant_id), 64'(3));
      chk("stab_addr3", 64'(bus_addr), 64'(30'h333));
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("stab_ack3", 64'(req_ack), 64'(4'b1000));
      req_valid[3] = 1'b0;
      tick();
      chk("stab_next0", 64'(grant_id), 64'(0));
      chk("stab_addr0", 64'(bus_addr), 64'(30'h444));
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("stab_ack0", 64'(req_ack), 64'(4'b0001));
      req_valid = '0;
      tick();

      // Reset while a read is in flight
      addr_a[2] = 30'h222;
      req_valid[2] = 1'b1;
      tick();
      chk("rst_pre_busy", 64'({bus_rd, busy}), 64'(2'b11));
      rst_n = 1'b0;
      req_valid = 4'b1110;
      addr_a[1] = 30'h1_1111;
      tick();
      rst_n = 1'b1;
      chk_zero("rst_mid");
      mem_ack = 1'b1; mem_rdata = 32'h0BAD_0ACC;
      tick();
      mem_ack = 1'b0;
      chk("rst_late_ack",    64'(req_ack), 64'(0));
      chk("rst_first_grant", 64'(grant_id), 64'(1));
      chk("rst_first_addr",  64'(bus_addr), 64'(30'h1_1111));
      chk("rst_first_read",  64'(bus_rd), 64'(1));
      mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
      tick();
      mem_ack = 1'b0;
      chk("rst_first_ack",  64'(req_ack), 64'(4'b0010));
      chk("rst_first_data", 64'(req_rdata), 64'(32'h1357_9BDF));
      req_valid = '0;
      tick();
      chk("rst_idle", 64'(busy), 64'(0));

      // Randomized traffic against the transaction-level model
      do_reset();
      m_last = N - 1; m_gid = 0; m_busy = 1'b0; m_cur = 0; m_start = 0; ack_at = -1;
      m_wr = 1'b0; m_addr = '0; m_be = '0; m_wd = '0;
      for (int n = 0; n < 3200; n++) begin
         stopping = (n >= 3000);
         v_pre  = req_valid;
         a_pre  = mem_ack;
         rd_pre = mem_rdata;
         tick();
         mem_ack = 1'b0;
         e_ack = '0; e_err = '0; e_rd = '0;
         if (!m_busy) begin
            if (v_pre != '0) begin
               m_cur   = rr_pick(v_pre, m_last);
               m_last  = m_cur;
               m_gid   = m_cur;
               m_busy  = 1'b1;
               m_start = n;
               m_wr    = req_write[IW'(m_cur)];
               m_addr  = addr_a[IW'(m_cur)];
               m_be    = be_a[IW'(m_cur)];
               m_wd    = wd_a[IW'(m_cur)];
               r = $urandom_range(0, 15);
               if (r < 10)       d = r % 5;
               else if (r == 10) d = TO - 2;
               else if (r == 11) d = TO - 1;
               else if (r == 12) d = TO;
               else if (r == 13) d = -1;
               else              d = 1;
               ack_at = (d < 0) ? -1 : n + d;
            end
         end else if (a_pre) begin
            e_ack  = 4'(1) << m_cur;
            e_rd   = rd_pre;
            m_busy = 1'b0;
         end else if (n - m_start == TO) begin
            e_ack  = 4'(1) << m_cur;
            e_err  = 4'(1) << m_cur;
            m_busy = 1'b0;
         end
         chk("rand_ack",  64'(req_ack),  64'(e_ack));
         chk("rand_err",  64'(req_err),  64'(e_err));
         chk("rand_busy", 64'(busy),     64'(m_busy));
         chk("rand_rd",   64'(bus_rd),   64'(m_busy && !m_wr));
         chk("rand_wr",   64'(bus_wr),   64'(m_busy && m_wr));
         chk("rand_gid",  64'(grant_id), 64'(m_gid));
         if (m_busy) begin
            chk("rand_addr", 64'(bus_addr), 64'(m_addr));
            chk("rand_be",   64'(bus_be),   64'(m_be));
            chk("rand_wd",   64'(bus_wd),   64'(m_wd));
         end
         if (e_ack != '0) chk("rand_rdata", 64'(req_rdata), 64'(e_rd));
         for (int i = 0; i < N; i++) begin
            if (e_ack[i]) req_valid[i] = 1'b0;
            else if (!req_valid[i] && !stopping && $urandom_range(0, 3) == 0) begin
               req_valid[i] = 1'b1;
               req_write[i] = 1'($urandom_range(0, 1));
               addr_a[i]    = 30'($urandom);
               be_a[i]      = 4'($urandom);
               wd_a[i]      = $urandom;
            end else if (m_busy && $urandom_range(0, 7) == 0) begin
               addr_a[i] = 30'($urandom);
               wd_a[i]   = $urandom;
            end
         end
         mem_ack   = (n == ack_at) || (!m_busy && $urandom_range(0, 9) == 0);
         mem_rdata = $urandom;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
